// File: rtl/cdc_pkg.sv
// Shared definitions for the command-receive clock-domain crossing.
// Contents:
//   DATA_W_DEF      default command word width
//   SYNC_STAGES_DEF default depth of the req synchronizer
//   state_t         receive FSM state encoding
package cdc_pkg;

    localparam int DATA_W_DEF      = 16;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_HOLD    = 2'd2,
        ST_ACK     = 2'd3
    } state_t;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for signals entering the clk domain asynchronously.
// Ports:
//   clk    destination clock
//   rst_n  asynchronous active-low reset, clears every stage
//   d      asynchronous input
//   q      synchronized output (last stage)
// STAGES is meant to be 2..4.
module sync_ff #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/cdc_cmd_rx.sv
// Receiver side of a 4-phase req/ack command crossing into clk_fast.
// The req line is synchronized; the data word is sampled only once the
// synchronized req is seen, relying on the sender holding it stable.
// Ports:
//   clk_fast    destination clock
//   rstn_fast   asynchronous active-low reset
//   req_async   4-phase request from the sender
//   data_async  command word, stable while req_async is high
//   ack_async   4-phase acknowledge to the sender (flop output)
//   cmd_data    captured command word
//   cmd_valid   cmd_data valid toward the consumer
//   cmd_ready   consumer accepts when cmd_valid & cmd_ready
//   busy        FSM is not idle
//   cmd_cnt     accepted-command count, wraps
//   err_cnt     protocol violation count, saturates
//
// state      | meaning
// -----------+-----------------------------------------------
// ST_IDLE    | waiting for an armed, synchronized request
// ST_CAPTURE | one cycle: sample data_async into cmd_data
// ST_HOLD    | cmd_valid high, waiting for cmd_ready
// ST_ACK     | ack_async high, waiting for req to drop
module cdc_cmd_rx
    import cdc_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic              clk_fast,
    input  logic              rstn_fast,
    input  logic              req_async,
    input  logic [DATA_W-1:0] data_async,
    output logic              ack_async,
    output logic [DATA_W-1:0] cmd_data,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              busy,
    output logic [15:0]       cmd_cnt,
    output logic [7:0]        err_cnt
);

    state_t state, state_nxt;
    logic   req_sync;
    logic   sync_primed;
    logic   armed;
    logic   viol_seen;
    logic   capture;
    logic   accept;
    logic   viol;

    sync_ff #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_req_sync (
        .clk   (clk_fast),
        .rst_n (rstn_fast),
        .d     (req_async),
        .q     (req_sync)
    );

    // req_sync reads 0 for the first SYNC_STAGES edges after reset no matter
    // what the sender is doing. A matching chain fed with 1 marks when
    // req_sync starts reflecting the real line, so a request that was already
    // high at reset release cannot arm the receiver through those zeros.
    sync_ff #(.STAGES(SYNC_STAGES), .WIDTH(1)) u_primed (
        .clk   (clk_fast),
        .rst_n (rstn_fast),
        .d     (1'b1),
        .q     (sync_primed)
    );

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_sync && armed) state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                capture   = 1'b1;
                state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (cmd_ready) begin
                    accept    = 1'b1;
                    state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!req_sync) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // One count per request: viol_seen masks the remaining cycles.
        viol = ((state == ST_CAPTURE) || (state == ST_HOLD)) && !req_sync && !viol_seen;
    end

    always_ff @(posedge clk_fast or negedge rstn_fast) begin
        if (!rstn_fast) begin
            state     <= ST_IDLE;
            ack_async <= 1'b0;
            cmd_data  <= '0;
            cmd_cnt   <= 16'd0;
            err_cnt   <= 8'd0;
            armed     <= 1'b0;
            viol_seen <= 1'b0;
        end else begin
            state     <= state_nxt;
            ack_async <= (state_nxt == ST_ACK);
            if (capture) cmd_data <= data_async;
            if (accept) cmd_cnt <= cmd_cnt + 16'd1;
            if (viol && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
            if (state == ST_IDLE) viol_seen <= 1'b0;
            else if (viol) viol_seen <= 1'b1;
            if (sync_primed && !req_sync) armed <= 1'b1;
        end
    end

    assign cmd_valid = (state == ST_HOLD);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_cdc_cmd_rx.sv
`timescale 1ns/1ps
module tb_cdc_cmd_rx;

    localparam int DW = 16;
    localparam int SS = 2;

    logic          clk_fast = 1'b0;
    logic          rstn_fast;
    logic          req_async;
    logic [DW-1:0] data_async;
    logic          ack_async;
    logic [DW-1:0] cmd_data;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          busy;
    logic [15:0]   cmd_cnt;
    logic [7:0]    err_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: transfer and violation counts from the protocol rules.
    int exp_cnt = 0;
    int exp_err = 0;

    cdc_cmd_rx #(.DATA_W(DW), .SYNC_STAGES(SS)) dut (
        .clk_fast   (clk_fast),
        .rstn_fast  (rstn_fast),
        .req_async  (req_async),
        .data_async (data_async),
        .ack_async  (ack_async),
        .cmd_data   (cmd_data),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .busy       (busy),
        .cmd_cnt    (cmd_cnt),
        .err_cnt    (err_cnt)
    );

    always #2.5 clk_fast = ~clk_fast;

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_fast);
        #1;
    endtask

    task automatic wait_valid(output int lat, output bit ok);
        lat = 0;
        ok  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            lat++;
            if (cmd_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, cmd_valid, 0);
        chk({tag, "_ack"},   ack_async, 0);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_data"},  cmd_data, 0);
        chk({tag, "_cnt"},   cmd_cnt, 0);
        chk({tag, "_err"},   err_cnt, 0);
    endtask

    // One complete handshake. bp = cycles of cmd_ready low while valid;
    // viol = sender drops req while the command is still held.
    task automatic xfer(input logic [15:0] d, input int bp, input bit viol, input bit full);
        int lat;
        bit ok;
        data_async = d;
        req_async  = 1'b1;
        cmd_ready  = (bp == 0) && !viol;
        wait_valid(lat, ok);
        chk("valid_seen", ok, 1);
        if (!ok) return;
        if (full) chk("latency", lat, SS + 2);
        chk("hold_data", cmd_data, d);
        chk("hold_ack", ack_async, 0);
        if (viol) begin
            req_async = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tick();
                if (full) begin
                    chk("viol_valid", cmd_valid, 1);
                    chk("viol_ack", ack_async, 0);
                end
            end
            exp_err = (exp_err < 255) ? exp_err + 1 : 255;
        end else begin
            for (int i = 0; i < bp; i++) begin
                tick();
                if (full) begin
                    chk("bp_valid", cmd_valid, 1);
                    chk("bp_data", cmd_data, d);
                    chk("bp_ack", ack_async, 0);
                end
            end
        end
        cmd_ready = 1'b1;
        tick();
        exp_cnt = (exp_cnt + 1) % 65536;
        chk("accept_ack", ack_async, 1);
        chk("accept_valid", cmd_valid, 0);
        chk("cmd_cnt", cmd_cnt, exp_cnt);
        chk("err_cnt", err_cnt, exp_err);
        cmd_ready = 1'b0;
        if (!viol) begin
            req_async = 1'b0;
            tick();
            chk("ack_hold1", ack_async, 1);
            tick();
            chk("ack_hold2", ack_async, 1);
            tick();
            chk("ack_fall", ack_async, 0);
        end else begin
            tick();
            chk("ack_one_cycle", ack_async, 0);
        end
        chk("idle_busy", busy, 0);
        data_async = 16'($urandom);
    endtask

    initial begin
        int lat;
        bit ok;

        // Reset with random inputs.
        rstn_fast  = 1'b0;
        req_async  = 1'($urandom);
        data_async = 16'($urandom);
        cmd_ready  = 1'($urandom);
        #1;
        for (int i = 0; i < 4; i++) begin
            req_async  = 1'($urandom);
            data_async = 16'($urandom);
            cmd_ready  = 1'($urandom);
            #5;
            chk_all_zero("reset");
        end
        req_async = 1'b0;
        cmd_ready = 1'b0;
        rstn_fast = 1'b1;
        repeat (4) tick();
        chk_all_zero("post_reset");

        // Single transfer with ready tied high, then backpressure.
        xfer(16'hA5C3, 0, 1'b0, 1'b1);
        xfer(16'h1234, 10, 1'b0, 1'b1);

        // Random words and backpressure lengths.
        for (int i = 0; i < 8; i++) begin
            xfer(16'($urandom), int'($urandom_range(0, 5)), 1'b0, 1'b1);
        end

        // Request already high across reset release: must not transfer.
        req_async = 1'b1;
        rstn_fast = 1'b0;
        #2;
        chk_all_zero("rst_req_hi");
        rstn_fast = 1'b1;
        exp_cnt = 0;
        exp_err = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stale_req_valid", cmd_valid, 0);
            chk("stale_req_busy", busy, 0);
        end
        req_async = 1'b0;
        repeat (3) tick();
        xfer(16'($urandom), 0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("one_xfer_valid", cmd_valid, 0);
        end
        chk("one_xfer_cnt", cmd_cnt, 1);

        // Protocol violations: one checked in detail, then saturation.
        xfer(16'($urandom), 0, 1'b1, 1'b1);
        chk("err_first", err_cnt, 1);
        for (int i = 0; i < 299; i++) begin
            xfer(16'($urandom), 0, 1'b1, 1'b0);
        end
        chk("err_saturated", err_cnt, 8'hFF);
        xfer(16'($urandom), 2, 1'b0, 1'b1);

        // Reset pulse mid-HOLD.
        data_async = 16'($urandom);
        req_async  = 1'b1;
        cmd_ready  = 1'b0;
        wait_valid(lat, ok);
        chk("midhold_reach", ok, 1);
        repeat (2) tick();
        rstn_fast = 1'b0;
        #1;
        chk_all_zero("midhold_rst");
        req_async = 1'b0;
        #1;
        rstn_fast = 1'b1;
        exp_cnt = 0;
        exp_err = 0;
        repeat (4) tick();
        xfer(16'($urandom), 1, 1'b0, 1'b1);

        // Reset pulse mid-ACK.
        data_async = 16'($urandom);
        req_async  = 1'b1;
        cmd_ready  = 1'b1;
        wait_valid(lat, ok);
        chk("midack_reach", ok, 1);
        tick();
        chk("midack_ack", ack_async, 1);
        rstn_fast = 1'b0;
        #1;
        chk_all_zero("midack_rst");
        req_async = 1'b0;
        cmd_ready = 1'b0;
        #1;
        rstn_fast = 1'b1;
        exp_cnt = 0;
        exp_err = 0;
        repeat (4) tick();
        xfer(16'($urandom), 0, 1'b0, 1'b1);

        // Counter wrap together with err saturation; counters preloaded.
        force dut.cmd_cnt = 16'hFFFE;
        force dut.err_cnt = 8'hFF;
        #1;
        release dut.cmd_cnt;
        release dut.err_cnt;
        exp_cnt = 16'hFFFE;
        exp_err = 255;
        xfer(16'($urandom), 0, 1'b0, 1'b1);
        chk("cnt_ffff", cmd_cnt, 16'hFFFF);
        xfer(16'($urandom), 1, 1'b1, 1'b1);
        chk("cnt_wrap", cmd_cnt, 16'h0000);
        chk("err_stuck", err_cnt, 8'hFF);
        xfer(16'($urandom), 0, 1'b0, 1'b1);
        chk("cnt_after_wrap", cmd_cnt, 16'h0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cdc_cmd_rx.md
CDC_CMD_RX -- requirements
Module: cdc_cmd_rx

Interface
REQ-001 Parameter DATA_W, default 16, width of the command word carried across the crossing.
REQ-002 Parameter SYNC_STAGES, default 2, number of flip-flops in the req synchronizer (legal range 2..4).
REQ-003 clk_fast  input  1  sole clock of the block (destination domain); all state updates on its rising edge.
REQ-004 rstn_fast  input  1  reset, asynchronous and active-low.
REQ-005 req_async  input  1  4-phase request from the slow-domain sender, asynchronous to clk_fast.
REQ-006 data_async  input  DATA_W  command word, held stable by the sender while req_async is high.
REQ-007 ack_async  output  1  4-phase acknowledge to the sender, driven directly from a flop.
REQ-008 cmd_data  output  DATA_W  captured command word.
REQ-009 cmd_valid  output  1  cmd_data valid toward the fast-domain consumer.
REQ-010 cmd_ready  input  1  consumer accepts cmd_data on the edge where cmd_valid and cmd_ready are both high.
REQ-011 busy  output  1  high whenever the FSM is not IDLE.
REQ-012 cmd_cnt  output  16  count of accepted commands; wraps 0xFFFF -> 0x0000.
REQ-013 err_cnt  output  8  count of protocol violations; saturates at 0xFF.

Function
REQ-014 req_async shall pass through SYNC_STAGES flops before any use; the last stage output is req_sync. data_async shall never be synchronized bit-wise, only sampled in CAPTURE.
REQ-015 FSM states: IDLE, CAPTURE, HOLD, ACK.
REQ-016 IDLE -> CAPTURE when req_sync = 1 and armed = 1; otherwise stay in IDLE.
REQ-017 armed is cleared by reset and set on the first edge where req_sync = 0; a request already high at reset release produces no transfer until req is seen low.
REQ-018 CAPTURE lasts exactly one cycle: cmd_data <= data_async, then -> HOLD.
REQ-019 HOLD: cmd_valid = 1, cmd_data stable; on the edge with cmd_ready = 1 -> ACK, cmd_cnt increments.
REQ-020 ACK: ack_async = 1; -> IDLE on the edge where req_sync = 0, and ack_async = 0 from that edge.
REQ-021 ack_async shall be 1 only in ACK, never during CAPTURE or HOLD (ack is held back by consumer backpressure).
REQ-022 Latency: if edge E0 first samples req_async = 1, cmd_valid shall be high after edge E(SYNC_STAGES+1) and ack_async shall rise on the accept edge.
REQ-023 Protocol violation: req_sync = 0 while in CAPTURE or HOLD; err_cnt increments once per violating request. The captured command is still delivered, and ACK then lasts one cycle.
REQ-024 If cmd_ready is already high when HOLD is entered, accept happens on the first HOLD edge, so cmd_valid is high for one cycle.
REQ-025 Simultaneous cmd_cnt wrap and err_cnt saturation are independent; neither blocks FSM progress.

Reset
REQ-026 Asserting rstn_fast low at any time, including mid-HOLD or mid-ACK, shall immediately force: state IDLE, all sync flops 0, armed 0, ack_async 0, cmd_valid 0, busy 0, cmd_data 0, cmd_cnt 0, err_cnt 0.
REQ-027 Reset deassertion is synchronized externally; the block adds no reset synchronizer.

Structure
REQ-028 Shared package cdc_pkg holds the FSM state enumeration and the DATA_W and SYNC_STAGES defaults.
REQ-029 The N-stage synchronizer shall be one sub-module, sync_ff, parameterized by stage count and marked for async-register placement.

Verification (DATA_W=16, SYNC_STAGES=2, clk_fast period 5 ns)
REQ-030 Reset: hold rstn_fast low 20 ns with random inputs -> all outputs 0, busy 0.
REQ-031 Single transfer: data_async=0xA5C3, req_async high, cmd_ready tied 1 -> cmd_valid high one cycle after edge E3 with cmd_data=0xA5C3; ack_async rises the same edge as accept; ack falls 3 edges after req_async low; cmd_cnt=1.
REQ-032 Backpressure: cmd_ready low 10 cycles then high -> cmd_valid held 10+ cycles, cmd_data stable at 0x1234, ack_async 0 until the accept edge.
REQ-033 req_async high through reset release -> no cmd_valid; after req low 3 cycles then high -> exactly one transfer.
REQ-034 req_async dropped during HOLD -> err_cnt=1, command delivered, ack_async high exactly one cycle; 300 such violations -> err_cnt=0xFF.
REQ-035 rstn_fast pulsed low mid-HOLD -> cmd_valid and ack_async drop asynchronously; next valid request completes normally; 65536 transfers -> cmd_cnt wraps to 0x0000.
